// File: rtl/mat_conv_pkg.sv
// Shared types and elaboration-time helpers for the 2-D convolution engine.
// Output-dimension and accumulator-width arithmetic live here so every file agrees on them.
package mat_conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CALC = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Kernel tap row/column counters; wide enough for K up to 7.
    localparam int TI_W = 3;

    function automatic int out_dim(input int size, input int k, input bit stride2, input bit pad);
        int s;
        s = stride2 ? 2 : 1;
        if (pad) return (size - 1) / s + 1;
        return (size - k) / s + 1;
    endfunction

    function automatic int pad_off(input int k);
        return (k - 1) / 2;
    endfunction

    function automatic bit acc_w_ok(input int acc_w, input int data_w, input int ker_w, input int k);
        longint max_v;
        max_v = longint'(k) * longint'(k) * ((longint'(1) << data_w) - 1) * ((longint'(1) << ker_w) - 1);
        return acc_w >= $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/conv_tap_addr_gen.sv
// Combinational tap address generator: output pixel (r,c) and kernel tap (i,j) to an
// image address, plus a flag saying whether that address lies inside the image.
module conv_tap_addr_gen
    import mat_conv_pkg::*;
#(
    parameter int IMG_ROWS = 10,
    parameter int IMG_COLS = 12,
    parameter int K        = 3,
    parameter int IDX_W    = 4
) (
    input  logic [IDX_W-1:0] i_r,
    input  logic [IDX_W-1:0] i_c,
    input  logic [TI_W-1:0]  i_ti,
    input  logic [TI_W-1:0]  i_tj,
    input  logic             i_stride,
    input  logic             i_pad,
    output logic [IDX_W-1:0] o_row,
    output logic [IDX_W-1:0] o_col,
    output logic             o_inb
);

    // Two's complement with a sign bit and one guard bit above the index width.
    localparam int SW = IDX_W + 2;
    localparam logic [SW-1:0] POFF = SW'(pad_off(K));

    logic [SW-1:0] w_rbase;
    logic [SW-1:0] w_cbase;
    logic [SW-1:0] w_off;
    logic [SW-1:0] w_row;
    logic [SW-1:0] w_col;

    always_comb begin
        w_off   = i_pad ? POFF : '0;
        w_rbase = i_stride ? {1'b0, i_r, 1'b0} : {2'b00, i_r};
        w_cbase = i_stride ? {1'b0, i_c, 1'b0} : {2'b00, i_c};
        w_row   = w_rbase + SW'(i_ti) - w_off;
        w_col   = w_cbase + SW'(i_tj) - w_off;
        o_inb   = !w_row[SW-1] && (w_row < SW'(IMG_ROWS)) &&
                  !w_col[SW-1] && (w_col < SW'(IMG_COLS));
        o_row   = w_row[IDX_W-1:0];
        o_col   = w_col[IDX_W-1:0];
    end

endmodule

// File: rtl/mat_conv_engine.sv
// Single-channel 2-D convolution engine: streams in a KxK kernel, reads the image from a
// synchronous pixel memory one tap per cycle, and emits one result per output pixel.
module mat_conv_engine
    import mat_conv_pkg::*;
#(
    parameter int IMG_ROWS = 10,
    parameter int IMG_COLS = 12,
    parameter int K        = 3,
    parameter int DATA_W   = 4,
    parameter int KER_W    = 4,
    parameter int ACC_W    = 12,
    parameter int IDX_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_stride,
    input  logic              cfg_pad,
    input  logic [KER_W-1:0]  kernel_in,
    input  logic              kernel_valid,
    output logic              kernel_ready,
    output logic              mem_rd_en,
    output logic [IDX_W-1:0]  mem_row,
    output logic [IDX_W-1:0]  mem_col,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_elem,
    output logic [IDX_W-1:0]  out_row_idx,
    output logic [IDX_W-1:0]  out_col_idx,
    output logic              out_row_end,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       cycle_count,
    output state_t            dbg_state
);

    localparam int KK    = K * K;
    localparam int TAP_W = $clog2(KK + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid/out_elem/indices stay frozen until out_ready is seen, kernel_ready is pure LOAD.

    if (!acc_w_ok(ACC_W, DATA_W, KER_W, K)) begin : g_acc_w_check
        $error("mat_conv_engine: ACC_W too narrow for K, DATA_W and KER_W");
    end

    localparam logic [IDX_W-1:0] RMAX_V1 = IDX_W'(out_dim(IMG_ROWS, K, 1'b0, 1'b0) - 1);
    localparam logic [IDX_W-1:0] RMAX_V2 = IDX_W'(out_dim(IMG_ROWS, K, 1'b1, 1'b0) - 1);
    localparam logic [IDX_W-1:0] RMAX_S1 = IDX_W'(out_dim(IMG_ROWS, K, 1'b0, 1'b1) - 1);
    localparam logic [IDX_W-1:0] RMAX_S2 = IDX_W'(out_dim(IMG_ROWS, K, 1'b1, 1'b1) - 1);
    localparam logic [IDX_W-1:0] CMAX_V1 = IDX_W'(out_dim(IMG_COLS, K, 1'b0, 1'b0) - 1);
    localparam logic [IDX_W-1:0] CMAX_V2 = IDX_W'(out_dim(IMG_COLS, K, 1'b1, 1'b0) - 1);
    localparam logic [IDX_W-1:0] CMAX_S1 = IDX_W'(out_dim(IMG_COLS, K, 1'b0, 1'b1) - 1);
    localparam logic [IDX_W-1:0] CMAX_S2 = IDX_W'(out_dim(IMG_COLS, K, 1'b1, 1'b1) - 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_stride;
    logic                r_pad;
    logic [KER_W-1:0]    r_ker [KK];
    logic [TAP_W-1:0]    r_kidx;
    logic [TAP_W-1:0]    r_tap;
    logic [TI_W-1:0]     r_ti;
    logic [TI_W-1:0]     r_tj;
    logic [IDX_W-1:0]    r_row;
    logic [IDX_W-1:0]    r_col;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_out;
    logic                r_prev_inb;
    logic [IDX_W-1:0]    r_mem_row;
    logic [IDX_W-1:0]    r_mem_col;
    logic [15:0]         r_cc;

    logic                w_calc;
    logic                w_emit;
    logic                w_issue;
    logic                w_start_acc;
    logic                w_last;
    logic                w_row_end;
    logic                w_inb;
    logic [IDX_W-1:0]    w_addr_row;
    logic [IDX_W-1:0]    w_addr_col;
    logic [IDX_W-1:0]    w_r_max;
    logic [IDX_W-1:0]    w_c_max;
    logic [TAP_W-1:0]    w_kprev;
    logic [ACC_W-1:0]    w_prod;

    conv_tap_addr_gen #(
        .IMG_ROWS (IMG_ROWS),
        .IMG_COLS (IMG_COLS),
        .K        (K),
        .IDX_W    (IDX_W)
    ) u_addr (
        .i_r      (r_row),
        .i_c      (r_col),
        .i_ti     (r_ti),
        .i_tj     (r_tj),
        .i_stride (r_stride),
        .i_pad    (r_pad),
        .o_row    (w_addr_row),
        .o_col    (w_addr_col),
        .o_inb    (w_inb)
    );

    always_comb begin
        w_calc      = (r_state == ST_CALC);
        w_emit      = (r_state == ST_EMIT);
        w_issue     = w_calc && (r_tap != TAP_W'(KK));
        w_start_acc = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_r_max     = r_pad ? (r_stride ? RMAX_S2 : RMAX_S1) : (r_stride ? RMAX_V2 : RMAX_V1);
        w_c_max     = r_pad ? (r_stride ? CMAX_S2 : CMAX_S1) : (r_stride ? CMAX_V2 : CMAX_V1);
        w_row_end   = w_emit && (r_col == w_c_max);
        w_last      = w_row_end && (r_row == w_r_max);
        // Data returned this cycle belongs to the tap issued last cycle.
        w_kprev     = r_tap - TAP_W'(1);
        w_prod      = r_prev_inb ? ACC_W'(mem_rd_data) * ACC_W'(r_ker[w_kprev]) : '0;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_nx = ST_LOAD;
            ST_LOAD:          if (kernel_valid && (r_kidx == TAP_W'(KK - 1))) w_state_nx = ST_CALC;
            ST_CALC:          if (r_tap == TAP_W'(KK)) w_state_nx = ST_EMIT;
            ST_EMIT:          if (out_ready) w_state_nx = w_last ? ST_DONE : ST_CALC;
            default:          w_state_nx = ST_IDLE;
        endcase
        if (abort) w_state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride   <= 1'b0;
            r_pad      <= 1'b0;
            for (int n = 0; n < KK; n++) r_ker[n] <= '0;
            r_kidx     <= '0;
            r_tap      <= '0;
            r_ti       <= '0;
            r_tj       <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_acc      <= '0;
            r_out      <= '0;
            r_prev_inb <= 1'b0;
            r_mem_row  <= '0;
            r_mem_col  <= '0;
            r_cc       <= '0;
        end else begin
            r_prev_inb <= mem_rd_en;
            if (mem_rd_en) begin
                r_mem_row <= w_addr_row;
                r_mem_col <= w_addr_col;
            end
            if (w_start_acc) begin
                r_stride <= cfg_stride;
                r_pad    <= cfg_pad;
                r_cc     <= '0;
                r_kidx   <= '0;
                r_tap    <= '0;
                r_ti     <= '0;
                r_tj     <= '0;
                r_row    <= '0;
                r_col    <= '0;
            end
            if (!abort) begin
                if ((w_calc || w_emit) && (r_cc != 16'hFFFF)) r_cc <= r_cc + 16'd1;
                if ((r_state == ST_LOAD) && kernel_valid) begin
                    r_ker[r_kidx] <= kernel_in;
                    r_kidx        <= r_kidx + TAP_W'(1);
                end
                if (w_calc) begin
                    r_acc <= (r_tap == '0) ? '0 : r_acc + w_prod;
                    if (r_tap == TAP_W'(KK)) begin
                        r_out <= r_acc + w_prod;
                        r_tap <= '0;
                        r_ti  <= '0;
                        r_tj  <= '0;
                    end else begin
                        r_tap <= r_tap + TAP_W'(1);
                        if (r_tj == TI_W'(K - 1)) begin
                            r_tj <= '0;
                            r_ti <= r_ti + TI_W'(1);
                        end else begin
                            r_tj <= r_tj + TI_W'(1);
                        end
                    end
                end
                if (w_emit && out_ready && !w_last) begin
                    if (w_row_end) begin
                        r_col <= '0;
                        r_row <= r_row + IDX_W'(1);
                    end else begin
                        r_col <= r_col + IDX_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        kernel_ready = (r_state == ST_LOAD);
        mem_rd_en    = w_issue && w_inb;
        mem_row      = mem_rd_en ? w_addr_row : r_mem_row;
        mem_col      = mem_rd_en ? w_addr_col : r_mem_col;
        out_valid    = w_emit;
        out_elem     = r_out;
        out_row_idx  = r_row;
        out_col_idx  = r_col;
        out_row_end  = w_row_end;
        out_last     = w_last;
        busy         = (r_state == ST_LOAD) || w_calc || w_emit;
        done         = (r_state == ST_DONE);
        cycle_count  = r_cc;
        dbg_state    = r_state;
    end

endmodule

// File: tb/tb_mat_conv_engine.sv
// Scoreboard bench for mat_conv_engine: runs push expected results, a monitor pops them
// on every output handshake; directed scenarios cover padding, stride, stalls and abort.
module tb_mat_conv_engine;
    import mat_conv_pkg::*;

    localparam int ROWS = 10;
    localparam int COLS = 12;
    localparam int KD   = 3;
    localparam int KK   = KD * KD;
    localparam int DW   = 4;
    localparam int KW   = 4;
    localparam int AW   = 12;
    localparam int IW   = 4;
    localparam int EW   = 2 + 2 * IW + AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_stride = 1'b0;
    logic          cfg_pad = 1'b0;
    logic [KW-1:0] kernel_in = '0;
    logic          kernel_valid = 1'b0;
    logic          kernel_ready;
    logic          mem_rd_en;
    logic [IW-1:0] mem_row;
    logic [IW-1:0] mem_col;
    logic [DW-1:0] mem_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_elem;
    logic [IW-1:0] out_row_idx;
    logic [IW-1:0] out_col_idx;
    logic          out_row_end;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [15:0]   cycle_count;
    state_t        dbg_state;

    mat_conv_engine #(
        .IMG_ROWS (ROWS), .IMG_COLS (COLS), .K (KD),
        .DATA_W (DW), .KER_W (KW), .ACC_W (AW), .IDX_W (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_stride   (cfg_stride),
        .cfg_pad      (cfg_pad),
        .kernel_in    (kernel_in),
        .kernel_valid (kernel_valid),
        .kernel_ready (kernel_ready),
        .mem_rd_en    (mem_rd_en),
        .mem_row      (mem_row),
        .mem_col      (mem_col),
        .mem_rd_data  (mem_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_elem     (out_elem),
        .out_row_idx  (out_row_idx),
        .out_col_idx  (out_col_idx),
        .out_row_end  (out_row_end),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .cycle_count  (cycle_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- image memory model ----------------
    int img [ROWS][COLS];
    int ker [KK];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= DW'(img[mem_row][mem_col]);
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_res, n_last, n_row_end, n_rd_first, first_elem, last_elem;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int ref_conv(input int r, input int c, input int s, input bit pad);
        int acc, off, rr, cc;
        acc = 0;
        off = pad ? (KD - 1) / 2 : 0;
        for (int i = 0; i < KD; i++) begin
            for (int j = 0; j < KD; j++) begin
                rr = r * s + i - off;
                cc = c * s + j - off;
                if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) acc += img[rr][cc] * ker[i * KD + j];
            end
        end
        return acc;
    endfunction

    // ---------------- monitor ----------------
    logic [EW-1:0] mon_cur, mon_held, mon_exp;
    bit            mon_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_stall = 1'b0;
        end else begin
            if (mem_rd_en) begin
                check("rd_addr_in_image", (mem_row < ROWS) && (mem_col < COLS), 1);
                if (n_res == 0) n_rd_first++;
            end
            if (out_valid) begin
                mon_cur = {out_last, out_row_end, out_row_idx, out_col_idx, out_elem};
                if (mon_stall) check("stall_stable", mon_cur, mon_held);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", mon_cur, 0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("result", mon_cur, mon_exp);
                    end
                    if (n_res == 0) first_elem = int'(out_elem);
                    last_elem = int'(out_elem);
                    n_res++;
                    if (out_last) n_last++;
                    if (out_row_end) n_row_end++;
                    mon_stall = 1'b0;
                end else begin
                    mon_stall = 1'b1;
                    mon_held  = mon_cur;
                end
            end else begin
                if (mon_stall && !abort) check("valid_held_in_stall", 0, 1);
                mon_stall = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_img_diag();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = (r + c) % 10;
    endtask

    task automatic fill_ker(input int mode);
        for (int k = 0; k < KK; k++) begin
            case (mode)
                0:       ker[k] = (k == KK / 2) ? 1 : 0;
                1:       ker[k] = 1;
                2:       ker[k] = k + 1;
                3:       ker[k] = (k % 3) * 5 + 2;
                default: ker[k] = 15;
            endcase
        end
    endtask

    task automatic start_run(input bit stride, input bit pad);
        cfg_stride = stride;
        cfg_pad    = pad;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic load_kernel();
        int t;
        for (t = 0; t < 20 && !kernel_ready; t++) tick();
        check("kernel_ready_in_load", kernel_ready, 1);
        for (int k = 0; k < KK; k++) begin
            if (k == 4) begin
                kernel_valid = 1'b0;
                tick();
            end
            kernel_in    = KW'(ker[k]);
            kernel_valid = 1'b1;
            tick();
        end
        kernel_valid = 1'b0;
        check("kernel_ready_dropped", kernel_ready, 0);
    endtask

    task automatic run_conv(input bit stride, input bit pad, input int stall,
                            input bit start_in_calc, input bit junk_kernel);
        int s, nr, nc, t, cc0;
        s  = stride ? 2 : 1;
        nr = pad ? (ROWS - 1) / s + 1 : (ROWS - KD) / s + 1;
        nc = pad ? (COLS - 1) / s + 1 : (COLS - KD) / s + 1;
        exp_q.delete();
        n_res = 0; n_last = 0; n_row_end = 0; n_rd_first = 0;
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                exp_q.push_back({(r == nr - 1) && (c == nc - 1), c == nc - 1,
                                 IW'(r), IW'(c), AW'(ref_conv(r, c, s, pad))});
        out_ready = (stall == 0);
        start_run(stride, pad);
        load_kernel();
        if (junk_kernel) begin
            kernel_in    = '1;
            kernel_valid = 1'b1;
            repeat (3) tick();
            kernel_valid = 1'b0;
        end
        if (start_in_calc) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("start_ignored_state", longint'(dbg_state), longint'(ST_CALC));
        end
        if (stall > 0) begin
            for (t = 0; t < 100 && !out_valid; t++) tick();
            check("first_emit_seen", out_valid, 1);
            cc0 = int'(cycle_count);
            check("cc_at_first_emit", cc0, KK + 1);
            repeat (stall) tick();
            check("cc_after_stall", cycle_count, cc0 + stall);
            out_ready = 1'b1;
        end
        for (t = 0; t < 3000 && !done; t++) tick();
        check("run_done", done, 1);
        check("busy_after_done", busy, 0);
        tick();
        check("queue_drained", exp_q.size(), 0);
        check("result_count", n_res, nr * nc);
        check("out_last_count", n_last, 1);
        check("row_end_count", n_row_end, nr);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_kernel_ready", kernel_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_out_elem", out_elem, 0);
        check("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", longint'(dbg_state), longint'(ST_IDLE));

        // Centre-tap kernel, valid, stride 1
        fill_img_diag();
        fill_ker(0);
        run_conv(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("t1_first", first_elem, 2);
        check("t1_last", last_elem, 8);
        check("t1_cycles", cycle_count, 880);
        check("t1_done_holds", done, 1);

        // All-ones kernel, same padding, stride 1
        fill_ker(1);
        run_conv(1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("t2_first", first_elem, 4);
        check("t2_corner_reads", n_rd_first, 4);

        // Valid, stride 2, with stray kernel beats and an ignored start during CALC
        fill_ker(2);
        run_conv(1'b1, 1'b0, 0, 1'b1, 1'b1);

        // Same padding, stride 2, first result held off for 5 cycles
        fill_ker(3);
        run_conv(1'b1, 1'b1, 5, 1'b0, 1'b0);
        check("t4_cycles", cycle_count, 30 * 11 + 5);

        // Full-scale pixels and kernel
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = 15;
        fill_ker(4);
        run_conv(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("t5_first", first_elem, 2025);
        check("t5_last", last_elem, 2025);

        // Abort mid-CALC, then abort racing start in IDLE, then a clean rerun
        fill_img_diag();
        fill_ker(0);
        exp_q.delete();
        start_run(1'b0, 1'b0);
        load_kernel();
        repeat (3) tick();
        check("abort_pre_state", longint'(dbg_state), longint'(ST_CALC));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", longint'(dbg_state), longint'(ST_IDLE));
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_kernel_ready", kernel_ready, 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_beats_start", longint'(dbg_state), longint'(ST_IDLE));
        fill_ker(2);
        run_conv(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("t6_first", first_elem, ref_conv(0, 0, 1, 1'b0));

        // Reset in the middle of a run
        start_run(1'b0, 1'b0);
        load_kernel();
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_state", longint'(dbg_state), longint'(ST_IDLE));
        check("midrst_cycle_count", cycle_count, 0);
        check("midrst_mem_rd_en", mem_rd_en, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
